// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: multi-channel push-button conditioner.
// Each raw button is synchronised into clk and debounced against a shared,
// free-running 1 ms timebase. Every channel produces a registered debounced
// level and a one-cycle pulse when a press is accepted.
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, a held
// button also produces auto-repeat pulses, first after REPEAT_DELAY_MS ticks
// and then every REPEAT_RATE_MS ticks.
module btn_debounce_pulse #(
   parameter int unsigned N_BTN           = 2,
   parameter int unsigned CLK_FREQ        = 125000000,
   parameter int unsigned DEBOUNCE_MS     = 20,
   parameter int unsigned REPEAT_DELAY_MS = 500,
   parameter int unsigned REPEAT_RATE_MS  = 100
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_pulse,
   output logic             tick_1ms
);

   localparam int unsigned TB_CNT = CLK_FREQ / 1000;
   localparam int unsigned TB_W   = (TB_CNT > 1) ? $clog2(TB_CNT) : 1;
   localparam int unsigned DCNT_W = 8;

   localparam logic [TB_W-1:0]   TB_LAST   = TB_W'(TB_CNT - 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_MS - 1);

   // Legal ranges for every module parameter.
   localparam bit CFG_OK = (N_BTN >= 1)
                        && (CLK_FREQ >= 1000) && ((CLK_FREQ % 1000) == 0)
                        && (DEBOUNCE_MS >= 1) && (DEBOUNCE_MS <= 255)
                        && (REPEAT_DELAY_MS >= 1) && (REPEAT_DELAY_MS <= 1023)
                        && (REPEAT_RATE_MS >= 1) && (REPEAT_RATE_MS <= 1023);

   // Refuse to elaborate an out-of-range configuration.
   if (!CFG_OK) begin : g_bad_cfg
      $error("btn_debounce_pulse: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } state_t;

   // Two-flop synchroniser.
   logic [N_BTN-1:0]  sync1_q, sync1_d;
   logic [N_BTN-1:0]  sync2_q, sync2_d;

   // Shared timebase.
   logic [TB_W-1:0]   tb_cnt_q, tb_cnt_d;
   logic              tick_q, tick_d;

   // Per-channel debounce state.
   state_t            state_q [N_BTN];
   state_t            state_d [N_BTN];
   logic [DCNT_W-1:0] dcnt_q  [N_BTN];
   logic [DCNT_W-1:0] dcnt_d  [N_BTN];
   logic [N_BTN-1:0]  level_q, level_d;
   logic [N_BTN-1:0]  pulse_q, pulse_d;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned RCNT_W = 10;
   localparam logic [RCNT_W-1:0] RPT_DELAY_LAST = RCNT_W'(REPEAT_DELAY_MS - 1);
   localparam logic [RCNT_W-1:0] RPT_RATE_LAST  = RCNT_W'(REPEAT_RATE_MS - 1);

   // Repeat tick counter and "first repeat already fired" flag per channel.
   logic [RCNT_W-1:0] rcnt_q  [N_BTN];
   logic [RCNT_W-1:0] rcnt_d  [N_BTN];
   logic [N_BTN-1:0]  rpt_q, rpt_d;
`endif

   // Synchroniser next state: shift raw input through two stages.
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
   end

   // Timebase next state: wrap at terminal count; strobe lands in that cycle.
   always_comb begin
      tb_cnt_d = (tb_cnt_q == TB_LAST) ? '0 : tb_cnt_q + TB_W'(1);
      tick_d   = (tb_cnt_d == TB_LAST);
   end

   // Synchroniser and timebase registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         tb_cnt_q <= '0;
         tick_q   <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         tb_cnt_q <= tb_cnt_d;
         tick_q   <= tick_d;
      end
   end

   // Per-channel FSM next state, debounce count, level and pulse.
   always_comb begin
      level_d = level_q;
      pulse_d = '0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_d   = rpt_q;
`endif
      for (int unsigned i = 0; i < N_BTN; i++) begin
         state_d[i] = state_q[i];
         dcnt_d[i]  = dcnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
         rcnt_d[i]  = rcnt_q[i];
`endif
         case (state_q[i])
            ST_IDLE: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_PRESS_WAIT;
                  dcnt_d[i]  = '0;
               end
            end

            ST_PRESS_WAIT: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_IDLE;
                  dcnt_d[i]  = '0;
               end else if (tick_q) begin
                  if (dcnt_q[i] == DCNT_LAST) begin
                     state_d[i] = ST_HELD;
                     dcnt_d[i]  = '0;
                     level_d[i] = 1'b1;
                     pulse_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                     rcnt_d[i]  = '0;
                     rpt_d[i]   = 1'b0;
`endif
                  end else begin
                     dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                  end
               end
            end

            ST_HELD: begin
               if (!sync2_q[i]) begin
                  state_d[i] = ST_RELEASE_WAIT;
                  dcnt_d[i]  = '0;
               end
`ifdef BTN_AUTOREPEAT_EN
               // Repeat counter runs only while stable in HELD; a release
               // bounce pauses it rather than restarting it.
               else if (tick_q) begin
                  if (rcnt_q[i] == (rpt_q[i] ? RPT_RATE_LAST : RPT_DELAY_LAST)) begin
                     rcnt_d[i]  = '0;
                     rpt_d[i]   = 1'b1;
                     pulse_d[i] = 1'b1;
                  end else begin
                     rcnt_d[i] = rcnt_q[i] + RCNT_W'(1);
                  end
               end
`endif
            end

            ST_RELEASE_WAIT: begin
               if (sync2_q[i]) begin
                  state_d[i] = ST_HELD;
                  dcnt_d[i]  = '0;
               end else if (tick_q) begin
                  if (dcnt_q[i] == DCNT_LAST) begin
                     state_d[i] = ST_IDLE;
                     dcnt_d[i]  = '0;
                     level_d[i] = 1'b0;
                  end else begin
                     dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                  end
               end
            end

            default: begin
               state_d[i] = ST_IDLE;
               dcnt_d[i]  = '0;
               level_d[i] = 1'b0;
            end
         endcase
      end
   end

   // Per-channel FSM registers and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            state_q[i] <= ST_IDLE;
            dcnt_q[i]  <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q[i]  <= '0;
`endif
         end
         level_q <= '0;
         pulse_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q   <= '0;
`endif
      end else begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            state_q[i] <= state_d[i];
            dcnt_q[i]  <= dcnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
            rcnt_q[i]  <= rcnt_d[i];
`endif
         end
         level_q <= level_d;
         pulse_q <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
         rpt_q   <= rpt_d;
`endif
      end
   end

   // Outputs come straight from flops.
   assign btn_level = level_q;
   assign btn_pulse = pulse_q;
   assign tick_1ms  = tick_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Testbench for btn_debounce_pulse: scoreboard of expected press pulses
// (mask plus cycle window) checked by a pulse monitor, with scenario tasks
// checking levels and timebase phase inline.
module tb_btn_debounce_pulse;

   localparam int unsigned N_BTN    = 2;
   localparam int unsigned CLK_FREQ = 10000;
   localparam int unsigned DEB_MS   = 3;
   localparam int unsigned RD_MS    = 5;
   localparam int unsigned RR_MS    = 2;

   // Pulse window, in cycle-counter units, relative to the cycle the raw edge
   // is driven: 2 sync cycles + 1 FSM entry + up to 3 tick periods.
   localparam int unsigned WIN_LO = 23;
   localparam int unsigned WIN_HI = 33;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned HOLD_CLEAN = 40;
`else
   localparam int unsigned HOLD_CLEAN = 100;
`endif

   typedef struct {
      logic [N_BTN-1:0] mask;
      int unsigned      lo;
      int unsigned      hi;
      bit               rel;
   } exp_t;

   logic             clk;
   logic             rst;
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_pulse;
   logic             tick_1ms;

   int               total = 0;
   int               bad   = 0;
   int unsigned      cyc   = 0;
   int unsigned      last_pulse = 0;
   logic [N_BTN-1:0] prev_pulse = '0;
   bit               mon_en = 1'b0;
   exp_t             exp_q[$];

   btn_debounce_pulse #(
      .N_BTN          (N_BTN),
      .CLK_FREQ       (CLK_FREQ),
      .DEBOUNCE_MS    (DEB_MS),
      .REPEAT_DELAY_MS(RD_MS),
      .REPEAT_RATE_MS (RR_MS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .tick_1ms (tick_1ms)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor: every observed pulse pops and checks one scoreboard entry.
   always @(negedge clk) begin : mon
      exp_t        e;
      int unsigned lo;
      int unsigned hi;
      if (mon_en && btn_pulse != '0) begin
         total++;
         if ((btn_pulse & prev_pulse) != '0) begin
            bad++;
            $display("FAIL pulse_width: pulse=%b prev=%b at cyc=%0d, required no back-to-back", btn_pulse, prev_pulse, cyc);
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got pulse=%b at cyc=%0d, required none", btn_pulse, cyc);
         end else begin
            e  = exp_q.pop_front();
            lo = e.rel ? last_pulse + e.lo : e.lo;
            hi = e.rel ? last_pulse + e.hi : e.hi;
            if (btn_pulse !== e.mask || cyc < lo || cyc > hi) begin
               bad++;
               $display("FAIL pulse_match: got pulse=%b at cyc=%0d, required %b in cyc %0d..%0d", btn_pulse, cyc, e.mask, lo, hi);
            end
         end
         total++;
         if ((btn_level & btn_pulse) !== btn_pulse) begin
            bad++;
            $display("FAIL level_align: level=%b pulse=%b, required level high on pulsed bits", btn_level, btn_pulse);
         end
         last_pulse = cyc;
      end
      prev_pulse = btn_pulse;
   end

   task automatic push_exp(input logic [N_BTN-1:0] m, input int unsigned lo, input int unsigned hi, input bit rel);
      exp_t e;
      e.mask = m;
      e.lo   = lo;
      e.hi   = hi;
      e.rel  = rel;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      logic exp_tick;
      rst     = 1'b1;
      btn_raw = '0;
      repeat (5) @(negedge clk);
      total++;
      if ({btn_level, btn_pulse, tick_1ms} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: level=%b pulse=%b tick=%b, required all 0", btn_level, btn_pulse, tick_1ms);
      end
      rst = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         exp_tick = ((n % 10) == 9);
         total++;
         if (tick_1ms !== exp_tick) begin
            bad++;
            $display("FAIL tick_phase: cycle %0d after release tick=%b, required %b", n, tick_1ms, exp_tick);
         end
      end
      total++;
      if (btn_level !== '0 || btn_pulse !== '0) begin
         bad++;
         $display("FAIL idle_outputs: level=%b pulse=%b, required 00/00", btn_level, btn_pulse);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_clean_press();
      btn_raw[0] = 1'b1;
      push_exp(2'b01, cyc + WIN_LO, cyc + WIN_HI, 1'b0);
      repeat (HOLD_CLEAN) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL clean_press_missing: pending=%0d, required 0", exp_q.size());
         exp_q.delete();
      end
      total++;
      if (btn_level !== 2'b01) begin
         bad++;
         $display("FAIL clean_press_level: level=%b, required 01", btn_level);
      end
      btn_raw[0] = 1'b0;
      repeat (50) @(negedge clk);
      total++;
      if (btn_level !== 2'b00) begin
         bad++;
         $display("FAIL clean_release_level: level=%b, required 00", btn_level);
      end
   endtask

   task automatic test_bouncy_press();
      for (int i = 0; i < 9; i++) begin
         btn_raw[0] = ((i % 2) == 0);
         if (i == 8) push_exp(2'b01, cyc + WIN_LO, cyc + WIN_HI, 1'b0);
         repeat (7) @(negedge clk);
      end
      repeat (33) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL bouncy_missing: pending=%0d, required 0", exp_q.size());
         exp_q.delete();
      end
      total++;
      if (btn_level !== 2'b01) begin
         bad++;
         $display("FAIL bouncy_level: level=%b, required 01", btn_level);
      end
   endtask

   task automatic test_release_glitch();
      btn_raw[0] = 1'b0;
      repeat (15) @(negedge clk);
      total++;
      if (btn_level !== 2'b01) begin
         bad++;
         $display("FAIL release_early: level=%b before glitch, required 01", btn_level);
      end
      btn_raw[0] = 1'b1;
      @(negedge clk);
      btn_raw[0] = 1'b0;
      repeat (21) @(negedge clk);
      total++;
      if (btn_level !== 2'b01) begin
         bad++;
         $display("FAIL release_glitch_restart: level=%b 22 cycles after glitch, required 01", btn_level);
      end
      repeat (18) @(negedge clk);
      total++;
      if (btn_level !== 2'b00) begin
         bad++;
         $display("FAIL release_fall: level=%b 40 cycles after glitch, required 00", btn_level);
      end
   endtask

   task automatic test_simultaneous();
      btn_raw = 2'b11;
      push_exp(2'b11, cyc + WIN_LO, cyc + WIN_HI, 1'b0);
      repeat (40) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL simul_missing: pending=%0d, required 0", exp_q.size());
         exp_q.delete();
      end
      total++;
      if (btn_level !== 2'b11) begin
         bad++;
         $display("FAIL simul_level: level=%b, required 11", btn_level);
      end
      btn_raw = 2'b00;
      repeat (50) @(negedge clk);
      total++;
      if (btn_level !== 2'b00) begin
         bad++;
         $display("FAIL simul_release: level=%b, required 00", btn_level);
      end
   endtask

   task automatic test_reset_mid_press();
      btn_raw[1] = 1'b1;
      repeat (15) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({btn_level, btn_pulse, tick_1ms} !== '0) begin
         bad++;
         $display("FAIL reset_mid_outputs: level=%b pulse=%b tick=%b, required all 0", btn_level, btn_pulse, tick_1ms);
      end
      rst = 1'b0;
      push_exp(2'b10, cyc + WIN_LO, cyc + WIN_HI, 1'b0);
      repeat (40) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL reset_repress_missing: pending=%0d, required 0", exp_q.size());
         exp_q.delete();
      end
      total++;
      if (btn_level !== 2'b10) begin
         bad++;
         $display("FAIL reset_repress_level: level=%b, required 10", btn_level);
      end
      btn_raw[1] = 1'b0;
      repeat (50) @(negedge clk);
      total++;
      if (btn_level !== 2'b00) begin
         bad++;
         $display("FAIL reset_repress_release: level=%b, required 00", btn_level);
      end
   endtask

   task automatic test_autorepeat();
      btn_raw[0] = 1'b1;
      push_exp(2'b01, cyc + WIN_LO, cyc + WIN_HI, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
      push_exp(2'b01, RD_MS * 10, RD_MS * 10, 1'b1);
      for (int k = 0; k < 3; k++) push_exp(2'b01, RR_MS * 10, RR_MS * 10, 1'b1);
`endif
      repeat (150) @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL repeat_missing: pending=%0d, required 0", exp_q.size());
         exp_q.delete();
      end
      btn_raw[0] = 1'b0;
      repeat (50) @(negedge clk);
      total++;
      if (btn_level !== 2'b00) begin
         bad++;
         $display("FAIL repeat_release: level=%b, required 00", btn_level);
      end
   endtask

   initial begin
      rst     = 1'b0;
      btn_raw = '0;
      #1;
      test_reset();
      test_clean_press();
      test_bouncy_press();
      test_release_glitch();
      test_simultaneous();
      test_reset_mid_press();
      test_autorepeat();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
